// File: rtl/plic_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plic_lite_pkg
//  Description : Shared constants and types for the plic_lite interrupt
//                controller: register offsets, FSM encoding, default width.
//  Revision    : 1.0 - initial release
// ============================================================================
package plic_lite_pkg;

    localparam int PRIO_W_DEFAULT = 3;

    localparam logic [7:0] OFF_PENDING   = 8'h00;
    localparam logic [7:0] OFF_ENABLE    = 8'h04;
    localparam logic [7:0] OFF_THRESHOLD = 8'h08;
    localparam logic [7:0] OFF_CLAIM     = 8'h0C;
    localparam logic [7:0] OFF_TRIGGER   = 8'h10;
    localparam logic [7:0] OFF_PRIO_BASE = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOTIFY  = 2'd1,
        SERVICE = 2'd2
    } plic_state_t;

endpackage
`default_nettype wire

// File: rtl/plic_lite_if.sv
`default_nettype none
// ============================================================================
//  Module      : plic_lite_if
//  Description : Register bus between software master and plic_lite.
//                One-cycle request pulse, one-cycle ack with read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface plic_lite_if;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/plic_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : plic_prio_arbiter
//  Description : Combinational priority pick over requesting sources.
//                Highest priority wins, ties go to the lowest index; the
//                winner is eligible only when its priority exceeds threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_prio_arbiter
    import plic_lite_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = PRIO_W_DEFAULT
) (
    input  logic [NUM_SRC-1:0]             req,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]              threshold,
    output logic [7:0]                     win_id,
    output logic [PRIO_W-1:0]              win_prio,
    output logic                           eligible
);

    logic w_found;

    // Scan upward, replacing the candidate only on strictly greater priority
    always_comb begin
        w_found  = 1'b0;
        win_id   = 8'd0;
        win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i] && (!w_found || (prio[i] > win_prio))) begin
                w_found  = 1'b1;
                win_id   = 8'(i + 1);
                win_prio = prio[i];
            end
        end
        eligible = w_found && (win_prio > threshold);
    end

endmodule
`default_nettype wire

// File: rtl/plic_lite.sv
`default_nettype none
// ============================================================================
//  Module      : plic_lite
//  Description : Lightweight platform interrupt controller. Per-source
//                edge/level gateways, priority arbitration with threshold,
//                claim/complete handshake, single outstanding interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = PRIO_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    plic_lite_if.slave         bus,
    output logic               peripheral_int,
    output logic [7:0]         peripheral_int_code
);

    localparam logic [5:0] c_W_PENDING   = OFF_PENDING[7:2];
    localparam logic [5:0] c_W_ENABLE    = OFF_ENABLE[7:2];
    localparam logic [5:0] c_W_THRESHOLD = OFF_THRESHOLD[7:2];
    localparam logic [5:0] c_W_CLAIM     = OFF_CLAIM[7:2];
    localparam logic [5:0] c_W_TRIGGER   = OFF_TRIGGER[7:2];
    localparam logic [5:0] c_W_PRIO_BASE = OFF_PRIO_BASE[7:2];

    logic [NUM_SRC-1:0]             r_pending, r_enable, r_trigger, r_src_prev;
    logic [PRIO_W-1:0]              r_threshold;
    logic [NUM_SRC-1:0][PRIO_W-1:0] r_prio;
    logic [7:0]                     r_in_service, r_code;
    plic_state_t                    r_state;
    logic                           r_int, r_ack;
    logic [31:0]                    r_rdata;

    logic               w_bus_go, w_wr, w_rd, w_claim_rd, w_complete_wr, w_claim_take;
    logic [5:0]         w_word;
    logic [7:0]         w_win_id, w_svc_id;
    logic [PRIO_W-1:0]  w_win_prio;
    logic               w_eligible;
    logic [NUM_SRC-1:0] w_set, w_clr;
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    // Requests overlapping an ack cycle are dropped
    assign w_bus_go      = bus.bus_req && !r_ack;
    assign w_wr          = w_bus_go && bus.bus_we;
    assign w_rd          = w_bus_go && !bus.bus_we;
    assign w_word        = bus.bus_addr[7:2];
    assign w_claim_rd    = w_rd && (w_word == c_W_CLAIM);
    assign w_complete_wr = w_wr && (w_word == c_W_CLAIM);
    assign w_claim_take  = w_claim_rd && (r_state == NOTIFY) && w_eligible;

    // The id being claimed this cycle already counts as in service, so a
    // held level source cannot re-pend across the claim edge.
    assign w_svc_id      = w_claim_take ? w_win_id : r_in_service;
    assign w_unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata, w_win_prio};

    plic_prio_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .req       (r_pending & r_enable),
        .prio      (r_prio),
        .threshold (r_threshold),
        .win_id    (w_win_id),
        .win_prio  (w_win_prio),
        .eligible  (w_eligible)
    );

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_gate
            assign w_set[i] = (r_trigger[i] ? (src_irq[i] & ~r_src_prev[i]) : src_irq[i])
                              && (w_svc_id != 8'(i + 1));
            assign w_clr[i] = w_claim_take && (w_win_id == 8'(i + 1));
        end
    endgenerate

    // Gateway: capture requests into pending; a new set beats a claim-clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= '0;
            r_src_prev <= '0;
        end else begin
            r_src_prev <= src_irq;
            r_pending  <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable    <= '0;
            r_threshold <= '0;
            r_trigger   <= '0;
            r_prio      <= '0;
        end else if (w_wr) begin
            if (w_word == c_W_ENABLE)    r_enable    <= bus.bus_wdata[NUM_SRC-1:0];
            if (w_word == c_W_THRESHOLD) r_threshold <= bus.bus_wdata[PRIO_W-1:0];
            if (w_word == c_W_TRIGGER)   r_trigger   <= bus.bus_wdata[NUM_SRC-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_word == c_W_PRIO_BASE + 6'(i)) r_prio[i] <= bus.bus_wdata[PRIO_W-1:0];
            end
        end
    end

    // Read data mux; unmapped words and unused bits read as zero
    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_W_PENDING:   w_rdata[NUM_SRC-1:0] = r_pending;
            c_W_ENABLE:    w_rdata[NUM_SRC-1:0] = r_enable;
            c_W_THRESHOLD: w_rdata[PRIO_W-1:0]  = r_threshold;
            c_W_CLAIM:     w_rdata[7:0]         = w_claim_take ? w_win_id : 8'd0;
            c_W_TRIGGER:   w_rdata[NUM_SRC-1:0] = r_trigger;
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_word == c_W_PRIO_BASE + 6'(i)) w_rdata[PRIO_W-1:0] = r_prio[i];
                end
            end
        endcase
    end

    // Bus response: one-cycle ack, read data held only with the ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_bus_go;
            r_rdata <= w_rd ? w_rdata : 32'd0;
        end
    end

    // Notification FSM: IDLE -> NOTIFY on eligible winner, claim -> SERVICE,
    // matching complete -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_int        <= 1'b0;
            r_code       <= 8'd0;
            r_in_service <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_eligible) begin
                        r_code  <= w_win_id;
                        r_int   <= 1'b1;
                        r_state <= NOTIFY;
                    end
                end
                NOTIFY: begin
                    if (w_claim_rd) begin
                        r_int <= 1'b0;
                        if (w_eligible) begin
                            r_in_service <= w_win_id;
                            r_state      <= SERVICE;
                        end else begin
                            r_state      <= IDLE;
                        end
                    end
                end
                SERVICE: begin
                    if (w_complete_wr && (bus.bus_wdata[7:0] == r_in_service)) begin
                        r_in_service <= 8'd0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_int   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign peripheral_int      = r_int;
    assign peripheral_int_code = r_code;
    assign bus.bus_ack         = r_ack;
    assign bus.bus_rdata       = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_plic_lite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plic_lite
//  Description : Directed, self-checking bench for plic_lite: register
//                table plus claim/complete scenario sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_lite;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] src_irq = 8'd0;
    logic       peripheral_int;
    logic [7:0] peripheral_int_code;

    int errors = 0;
    int checks = 0;

    plic_lite_if bus_if ();

    plic_lite #(
        .NUM_SRC (8),
        .PRIO_W  (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .src_irq             (src_irq),
        .bus                 (bus_if),
        .peripheral_int      (peripheral_int),
        .peripheral_int_code (peripheral_int_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_op(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic ack);
        @(negedge clk);
        if (bus_if.bus_ack) @(negedge clk);
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        @(posedge clk);
        #1;
        ack   = bus_if.bus_ack;
        rdata = bus_if.bus_rdata;
        bus_if.bus_req = 1'b0;
        bus_if.bus_we  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] rd_d;
        logic        ack;
        bus_op(1'b1, addr, data, rd_d, ack);
        check("write_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic rd(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd_d;
        logic        ack;
        bus_op(1'b0, addr, 32'd0, rd_d, ack);
        check({name, "_ack"}, {31'd0, ack}, 32'd1);
        check(name, rd_d, exp);
    endtask

    task automatic wait_int(input string name);
        int n;
        n = 0;
        while (peripheral_int !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'd0, peripheral_int}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src_irq          = 8'd0;
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = 8'd0;
        bus_if.bus_wdata = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,         32'hFF};
        vecs[2]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,         32'h7};
        vecs[4]  = '{1'b1, 8'h10, 32'h0000_01A5, 32'h0};
        vecs[5]  = '{1'b0, 8'h10, 32'h0,         32'hA5};
        vecs[6]  = '{1'b1, 8'h3C, 32'h0000_001D, 32'h0};
        vecs[7]  = '{1'b0, 8'h3C, 32'h0,         32'h5};
        vecs[8]  = '{1'b0, 8'h3E, 32'h0,         32'h5};
        vecs[9]  = '{1'b1, 8'h00, 32'h0000_00FF, 32'h0};
        vecs[10] = '{1'b0, 8'h00, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 8'hFC, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 8'h40, 32'h0000_0007, 32'h0};
        vecs[13] = '{1'b0, 8'h40, 32'h0,         32'h0};
        vecs[14] = '{1'b0, 8'h0C, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 8'h20, 32'h0,         32'h0};

        do_reset();
        #1;
        check("rst_int",   {31'd0, peripheral_int}, 32'd0);
        check("rst_code",  {24'd0, peripheral_int_code}, 32'd0);
        check("rst_ack",   {31'd0, bus_if.bus_ack}, 32'd0);
        check("rst_rdata", bus_if.bus_rdata, 32'd0);

        // Register table
        for (int i = 0; i < 16; i++) begin
            logic [31:0] rd_d;
            logic        ack;
            bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd_d, ack);
            check($sformatf("vec%0d_ack", i), {31'd0, ack}, 32'd1);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd_d, vecs[i].exp);
        end
        idle_cycles(3);
        check("table_no_int", {31'd0, peripheral_int}, 32'd0);

        // Single source, edge
        do_reset();
        wr(8'h04, 32'h01);
        wr(8'h20, 32'h3);
        wr(8'h08, 32'h0);
        wr(8'h10, 32'h01);
        @(negedge clk) src_irq = 8'h01;
        @(posedge clk) #1;
        check("edge_int_k", {31'd0, peripheral_int}, 32'd0);
        @(negedge clk) src_irq = 8'h00;
        @(posedge clk) #1;
        check("edge_int_k1", {31'd0, peripheral_int}, 32'd1);
        check("edge_code", {24'd0, peripheral_int_code}, 32'd1);
        rd("edge_claim", 8'h0C, 32'd1);
        check("edge_int_drop", {31'd0, peripheral_int}, 32'd0);
        wr(8'h0C, 32'd1);
        idle_cycles(4);
        check("edge_no_renotify", {31'd0, peripheral_int}, 32'd0);
        rd("edge_claim_idle", 8'h0C, 32'd0);

        // Priority and tie: ids 2,5 at prio 4, id 3 at prio 6
        do_reset();
        wr(8'h04, 32'h16);
        wr(8'h10, 32'h16);
        wr(8'h24, 32'h4);
        wr(8'h28, 32'h6);
        wr(8'h30, 32'h4);
        @(negedge clk) src_irq = 8'h16;
        @(negedge clk) src_irq = 8'h00;
        wait_int("prio_int1");
        check("prio_code1", {24'd0, peripheral_int_code}, 32'd3);
        rd("prio_claim1", 8'h0C, 32'd3);
        wr(8'h0C, 32'd3);
        wait_int("prio_int2");
        rd("prio_claim2", 8'h0C, 32'd2);
        wr(8'h0C, 32'd2);
        wait_int("prio_int3");
        rd("prio_claim3", 8'h0C, 32'd5);
        wr(8'h0C, 32'd5);
        idle_cycles(4);
        check("prio_done", {31'd0, peripheral_int}, 32'd0);

        // Threshold: equal priority is blocked, higher passes
        do_reset();
        wr(8'h04, 32'h01);
        wr(8'h08, 32'h4);
        wr(8'h20, 32'h4);
        @(negedge clk) src_irq = 8'h01;
        idle_cycles(5);
        check("thr_blocked", {31'd0, peripheral_int}, 32'd0);
        wr(8'h20, 32'h5);
        check("thr_ack_cycle", {31'd0, peripheral_int}, 32'd0);
        @(posedge clk) #1;
        check("thr_int", {31'd0, peripheral_int}, 32'd1);
        check("thr_code", {24'd0, peripheral_int_code}, 32'd1);

        // Level source held through claim/complete
        do_reset();
        wr(8'h04, 32'h08);
        wr(8'h2C, 32'h2);
        @(negedge clk) src_irq = 8'h08;
        wait_int("lvl_int");
        check("lvl_code", {24'd0, peripheral_int_code}, 32'd4);
        rd("lvl_claim", 8'h0C, 32'd4);
        rd("lvl_pending_svc", 8'h00, 32'd0);
        idle_cycles(2);
        check("lvl_int_svc", {31'd0, peripheral_int}, 32'd0);
        wr(8'h0C, 32'd4);
        check("lvl_gap0", {31'd0, peripheral_int}, 32'd0);
        @(posedge clk) #1;
        check("lvl_gap1", {31'd0, peripheral_int}, 32'd0);
        @(posedge clk) #1;
        check("lvl_renotify", {31'd0, peripheral_int}, 32'd1);
        check("lvl_recode", {24'd0, peripheral_int_code}, 32'd4);

        // Bad complete and spurious claim
        do_reset();
        wr(8'h04, 32'h02);
        wr(8'h24, 32'h1);
        @(negedge clk) src_irq = 8'h02;
        wait_int("bad_int");
        rd("bad_claim", 8'h0C, 32'd2);
        wr(8'h0C, 32'd7);
        idle_cycles(3);
        check("bad_stay_service", {31'd0, peripheral_int}, 32'd0);
        rd("bad_spurious_claim", 8'h0C, 32'd0);
        idle_cycles(2);
        check("bad_no_int", {31'd0, peripheral_int}, 32'd0);
        wr(8'h0C, 32'd2);
        wait_int("bad_renotify");
        check("bad_recode", {24'd0, peripheral_int_code}, 32'd2);
        rd("unmapped_fc", 8'hFC, 32'd0);

        // Reset while in NOTIFY
        do_reset();
        wr(8'h04, 32'h01);
        wr(8'h20, 32'h1);
        @(negedge clk) src_irq = 8'h01;
        wait_int("mid_int");
        @(negedge clk) rst = 1'b0;
        #1;
        check("mid_rst_int", {31'd0, peripheral_int}, 32'd0);
        check("mid_rst_code", {24'd0, peripheral_int_code}, 32'd0);
        @(negedge clk) rst = 1'b1;
        rd("mid_enable", 8'h04, 32'd0);
        idle_cycles(5);
        check("mid_no_int", {31'd0, peripheral_int}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
